// File: rtl/axis_join.sv
// axis_join: recombines the two lanes of a ping-pong AXI-Stream split back into
// one stream, taking beats from the lanes in strict alternation so the original
// beat order is restored. The first beat after reset is taken from START_PORT.
//
// The output stage is a main register plus a one-entry skid register. Upstream
// ready comes from a flop (!skid_valid), so there is no combinational path from
// m_axis_tready to either s_*_tready, and throughput is one beat per cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s00_axis_tvalid/tdata/tready  lane 00 input stream
//   s01_axis_tvalid/tdata/tready  lane 01 input stream
//   m_axis_tvalid/tdata/tready    merged output stream
//   beat_cnt                      beats accepted on m_axis since reset (wraps)
module axis_join #(
    parameter int DATA_WD    = 64,
    parameter int START_PORT = 1,
    parameter int CNT_WD     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s00_axis_tvalid,
    input  logic [DATA_WD-1:0] s00_axis_tdata,
    output logic               s00_axis_tready,
    input  logic               s01_axis_tvalid,
    input  logic [DATA_WD-1:0] s01_axis_tdata,
    output logic               s01_axis_tready,
    output logic               m_axis_tvalid,
    output logic [DATA_WD-1:0] m_axis_tdata,
    input  logic               m_axis_tready,
    output logic [CNT_WD-1:0]  beat_cnt
);

    localparam logic START_SEL = (START_PORT != 0);

    logic               sel;
    logic               m_valid;
    logic               skid_valid;
    logic [DATA_WD-1:0] main_data;
    logic [DATA_WD-1:0] skid_data;
    logic [CNT_WD-1:0]  cnt;

    logic               int_ready;
    logic               sel_valid;
    logic [DATA_WD-1:0] sel_data;
    logic               acc;
    logic               out_fire;

    // Ready is purely a function of skid occupancy, which is a flop.
    assign int_ready = ~skid_valid;

    assign sel_valid = sel ? s01_axis_tvalid : s00_axis_tvalid;
    assign sel_data  = sel ? s01_axis_tdata  : s00_axis_tdata;
    assign acc       = sel_valid & int_ready;
    assign out_fire  = m_valid & m_axis_tready;

    // Only the lane whose turn it is ever sees ready; the other lane waits.
    assign s00_axis_tready = int_ready & ~sel;
    assign s01_axis_tready = int_ready & sel;

    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = main_data;
    assign beat_cnt      = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel        <= START_SEL;
            m_valid    <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            cnt        <= '0;
        end else begin
            if (acc) begin
                sel <= ~sel;
            end

            if (out_fire) begin
                cnt <= cnt + CNT_WD'(1);
            end

            // acc and a full skid are mutually exclusive, so the skid drain
            // branch never has to deal with an incoming beat.
            if (out_fire && skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (acc && (!m_valid || out_fire)) begin
                main_data <= sel_data;
                m_valid   <= 1'b1;
            end else if (acc) begin
                skid_data  <= sel_data;
                skid_valid <= 1'b1;
            end else if (out_fire) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_join.sv
// Directed and random checks for axis_join: alternation order, ordering stall,
// skid behaviour under backpressure, mid-stream reset, and a START_PORT=0 /
// CNT_WD=4 instance for the opposite start lane and counter wrap.
module tb_axis_join;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s00_valid, s01_valid, s00_ready, s01_ready;
    logic [63:0] s00_data, s01_data;
    logic        m_valid, m_ready;
    logic [63:0] m_data;
    logic [31:0] beat_cnt;

    logic        b_s00_valid, b_s01_valid, b_s00_ready, b_s01_ready;
    logic [63:0] b_s00_data, b_s01_data;
    logic        b_m_valid, b_m_ready;
    logic [63:0] b_m_data;
    logic [3:0]  b_beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] q00[$];
    logic [63:0] q01[$];
    logic [63:0] out_q[$];
    int          out_cyc[$];
    int          acc_src[$];
    int          first_acc_cyc = -1;
    int          n_acc = 0;
    int          cyc = 0;
    bit          ready_cmd = 1'b0;
    bit          rand_mode = 1'b0;
    bit          acc00, acc01, hold00, hold01;

    localparam int N_RAND = 10000;

    axis_join #(.DATA_WD(64), .START_PORT(1), .CNT_WD(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .s00_axis_tvalid (s00_valid),
        .s00_axis_tdata  (s00_data),
        .s00_axis_tready (s00_ready),
        .s01_axis_tvalid (s01_valid),
        .s01_axis_tdata  (s01_data),
        .s01_axis_tready (s01_ready),
        .m_axis_tvalid   (m_valid),
        .m_axis_tdata    (m_data),
        .m_axis_tready   (m_ready),
        .beat_cnt        (beat_cnt)
    );

    axis_join #(.DATA_WD(64), .START_PORT(0), .CNT_WD(4)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .s00_axis_tvalid (b_s00_valid),
        .s00_axis_tdata  (b_s00_data),
        .s00_axis_tready (b_s00_ready),
        .s01_axis_tvalid (b_s01_valid),
        .s01_axis_tdata  (b_s01_data),
        .s01_axis_tready (b_s01_ready),
        .m_axis_tvalid   (b_m_valid),
        .m_axis_tdata    (b_m_data),
        .m_axis_tready   (b_m_ready),
        .beat_cnt        (b_beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] qget(input int i);
        return (i < out_q.size()) ? out_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic int cget(input int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -100;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q00.delete();
        q01.delete();
        out_q.delete();
        out_cyc.delete();
        acc_src.delete();
        first_acc_cyc = -1;
        n_acc = 0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic wait_skid_full(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_valid && !s00_ready && !s01_ready) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    // Lane driver and output recorder for the main instance. Transfers are
    // observed at the falling edge (they complete on the next rising edge);
    // inputs are updated 1 time unit after the rising edge.
    initial begin
        s00_valid = 1'b0; s00_data = '0;
        s01_valid = 1'b0; s01_data = '0;
        m_ready   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            acc00 = !rst && s00_valid && s00_ready;
            acc01 = !rst && s01_valid && s01_ready;
            if (acc00 || acc01) begin
                acc_src.push_back(acc01 ? 1 : 0);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                n_acc++;
            end
            if (!rst && m_valid && m_ready) begin
                out_q.push_back(m_data);
                out_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (acc00 && q00.size() > 0) void'(q00.pop_front());
            if (acc01 && q01.size() > 0) void'(q01.pop_front());
            hold00 = s00_valid && !acc00 && (q00.size() > 0);
            hold01 = s01_valid && !acc01 && (q01.size() > 0);
            s00_valid = hold00 || ((q00.size() > 0) && (!rand_mode || $urandom_range(3) != 0));
            s01_valid = hold01 || ((q01.size() > 0) && (!rand_mode || $urandom_range(3) != 0));
            s00_data  = (q00.size() > 0) ? q00[0] : '0;
            s01_data  = (q01.size() > 0) ? q01[0] : '0;
            m_ready   = rand_mode ? ($urandom_range(3) != 0) : ready_cmd;
        end
    end

    initial begin
        logic [63:0] held, exp_v, d0, d1;
        bit          stalled;
        int          cnt;

        b_s00_valid = 1'b0; b_s00_data = '0;
        b_s01_valid = 1'b0; b_s01_data = '0;
        b_m_ready   = 1'b0;

        // Reset state
        tick(2);
        do_reset();
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("rst_s01_ready", 64'(s01_ready), 64'd1);
        check("rst_s00_ready", 64'(s00_ready), 64'd0);

        // Basic alternation
        tick(1);
        do_reset();
        ready_cmd = 1'b1;
        q01.push_back(64'hA0); q01.push_back(64'hA2);
        q00.push_back(64'hA1); q00.push_back(64'hA3);
        tick(12);
        check("basic_count", 64'(out_q.size()), 64'd4);
        check("basic_0", qget(0), 64'hA0);
        check("basic_1", qget(1), 64'hA1);
        check("basic_2", qget(2), 64'hA2);
        check("basic_3", qget(3), 64'hA3);
        check("basic_latency", 64'(cget(0)), 64'(first_acc_cyc + 1));
        check("basic_back_to_back", 64'(cget(3)), 64'(cget(0) + 3));
        check("basic_beat_cnt", 64'(beat_cnt), 64'd4);

        // Ordering stall: only the wrong lane is valid
        do_reset();
        q00.push_back(64'h11);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s00_ready", 64'(s00_ready), 64'd0);
            check("stall_m_valid", 64'(m_valid), 64'd0);
        end
        tick(1);
        q01.push_back(64'h10);
        tick(8);
        check("stall_count", 64'(out_q.size()), 64'd2);
        check("stall_0", qget(0), 64'h10);
        check("stall_1", qget(1), 64'h11);

        // Backpressure and skid
        ready_cmd = 1'b0;
        out_q.delete();
        n_acc = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 1) q01.push_back(64'(i));
            else            q00.push_back(64'(i));
        end
        wait_skid_full("skid_full");
        @(posedge clk);
        #2;
        check("skid_buffered", 64'(n_acc), 64'd2);
        check("skid_no_output", 64'(out_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("skid_s00_ready", 64'(s00_ready), 64'd0);
            check("skid_s01_ready", 64'(s01_ready), 64'd0);
            check("skid_hold_data", m_data, 64'h1);
        end
        tick(1);
        ready_cmd = 1'b1;
        tick(20);
        check("skid_count", 64'(out_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("skid_order", qget(i), 64'(i + 1));

        // Reset mid-stream with main and skid both occupied
        ready_cmd = 1'b0;
        out_q.delete();
        q01.push_back(64'h20); q01.push_back(64'h22);
        q00.push_back(64'h21); q00.push_back(64'h23);
        wait_skid_full("mid_skid_full");
        check("mid_beat_cnt_before", 64'(beat_cnt), 64'd10);
        tick(1);
        rst = 1'b1;
        out_q.delete();
        acc_src.delete();
        tick(1);
        rst = 1'b0;
        ready_cmd = 1'b1;
        @(negedge clk);
        check("mid_m_valid", 64'(m_valid), 64'd0);
        check("mid_beat_cnt", 64'(beat_cnt), 64'd0);
        check("mid_s01_ready", 64'(s01_ready), 64'd1);
        tick(10);
        check("mid_first_src", 64'((acc_src.size() > 0) ? acc_src[0] : 2), 64'd1);
        check("mid_out_0", qget(0), 64'h22);
        check("mid_out_1", qget(1), 64'h23);

        // Random valid/ready, incrementing data split across lanes
        do_reset();
        rand_mode = 1'b1;
        for (int k = 0; k < N_RAND; k++) begin
            if (k % 2 == 0) q01.push_back(64'(k));
            else            q00.push_back(64'(k));
        end
        exp_v   = '0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 60000 && exp_v < 64'(N_RAND); c++) begin
            @(negedge clk);
            if (stalled) begin
                check("rand_hold_valid", 64'(m_valid), 64'd1);
                check("rand_hold_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                check("rand_order", m_data, exp_v);
                exp_v++;
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
        end
        check("rand_done", exp_v, 64'(N_RAND));
        @(posedge clk);
        #2;
        rand_mode = 1'b0;
        ready_cmd = 1'b0;
        @(negedge clk);
        check("rand_beat_cnt", 64'(beat_cnt), 64'(N_RAND));

        // START_PORT=0, CNT_WD=4 instance
        tick(1);
        do_reset();
        @(negedge clk);
        check("b_s00_ready", 64'(b_s00_ready), 64'd1);
        check("b_s01_ready", 64'(b_s01_ready), 64'd0);
        @(posedge clk);
        #2;
        b_s00_valid = 1'b1; b_s00_data = 64'hB0;
        b_s01_valid = 1'b1; b_s01_data = 64'hB1;
        b_m_ready   = 1'b1;
        cnt = 0;
        d0  = '0;
        d1  = '0;
        for (int c = 0; c < 100 && cnt < 17; c++) begin
            @(negedge clk);
            if (b_m_valid && b_m_ready) begin
                if (cnt == 0) d0 = b_m_data;
                if (cnt == 1) d1 = b_m_data;
                cnt++;
            end
        end
        check("b_out_count", 64'(cnt), 64'd17);
        check("b_first_data", d0, 64'hB0);
        check("b_second_data", d1, 64'hB1);
        @(posedge clk);
        #1;
        b_m_ready   = 1'b0;
        b_s00_valid = 1'b0;
        b_s01_valid = 1'b0;
        @(negedge clk);
        check("b_beat_cnt_wrap", 64'(b_beat_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
